// File: rtl/data_memory_stage_pkg.sv
// Shared definitions for the MEM-stage block: FSM encoding and counter/offset constants.
package data_memory_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned CNT_WIDTH   = 4;
    localparam int unsigned WORD_OFFSET = 2;

endpackage

// File: rtl/data_memory_stage_ram.sv
// Single-port word RAM: synchronous write, registered read, no reset.
module data_ram #(
    parameter int unsigned N          = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [N-1:0]          wdata,
    output logic [N-1:0]          rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [N-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_memory_stage.sv
// MEM pipeline stage: fixed-latency word loads/stores against an internal RAM,
// stalling upstream and emitting bubbles while an access is in flight.
module data_memory_stage
    import data_memory_stage_pkg::*;
#(
    parameter int unsigned N           = 32,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] ALU_result,
    input  logic [N-1:0] Write_data,
    input  logic [4:0]   WriteRegister,
    input  logic         MemRead,
    input  logic         MemWrite,
    input  logic         MemtoReg,
    input  logic         RegWrite,
    output logic [N-1:0] ALU_result_out,
    output logic [N-1:0] Read_data,
    output logic [4:0]   WriteRegister_out,
    output logic         MemtoReg_out,
    output logic         RegWrite_out,
    output logic         stall
);

    state_t                 state, state_next;
    logic [CNT_WIDTH-1:0]   count, count_next;

    logic [N-1:0]           lat_alu, lat_wdata, read_buf;
    logic [4:0]             lat_wreg;
    logic                   lat_mtr, lat_rw, lat_store;

    logic                   mem_op, commit, ram_we;
    logic [ADDR_WIDTH-1:0]  in_addr, lat_addr, ram_addr;
    logic [N-1:0]           ram_rdata;

    assign mem_op   = MemRead | MemWrite;
    assign in_addr  = ALU_result[WORD_OFFSET +: ADDR_WIDTH];
    assign lat_addr = lat_alu[WORD_OFFSET +: ADDR_WIDTH];
    assign commit   = (state == BUSY) && (count == '0);
    assign ram_we   = commit && lat_store && reset;

    // Present the incoming address while idle so the registered read is valid in the first BUSY cycle.
    assign ram_addr = (state == IDLE) ? in_addr : lat_addr;

    data_ram #(
        .N          (N),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (lat_wdata),
        .rdata (ram_rdata)
    );

    // State and wait counter register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Next-state logic and MEM/WB output muxing; everything is zero while reset is low.
    always_comb begin
        state_next        = state;
        count_next        = count;
        ALU_result_out    = '0;
        Read_data         = '0;
        WriteRegister_out = '0;
        MemtoReg_out      = 1'b0;
        RegWrite_out      = 1'b0;
        stall             = 1'b0;
        if (reset) begin
            unique case (state)
                IDLE: begin
                    if (mem_op) begin
                        stall      = 1'b1;
                        state_next = BUSY;
                        count_next = CNT_WIDTH'(WAIT_CYCLES - 1);
                    end else begin
                        ALU_result_out    = ALU_result;
                        WriteRegister_out = WriteRegister;
                        MemtoReg_out      = MemtoReg;
                        RegWrite_out      = RegWrite;
                    end
                end
                BUSY: begin
                    stall = 1'b1;
                    if (count == '0) begin
                        state_next = DONE;
                    end else begin
                        count_next = count - CNT_WIDTH'(1);
                    end
                end
                DONE: begin
                    ALU_result_out    = lat_alu;
                    Read_data         = read_buf;
                    WriteRegister_out = lat_wreg;
                    MemtoReg_out      = lat_mtr;
                    RegWrite_out      = lat_rw;
                    state_next        = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Instruction latches and load read buffer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lat_alu   <= '0;
            lat_wdata <= '0;
            lat_wreg  <= '0;
            lat_mtr   <= 1'b0;
            lat_rw    <= 1'b0;
            lat_store <= 1'b0;
            read_buf  <= '0;
        end else begin
            if ((state == IDLE) && mem_op) begin
                lat_alu   <= ALU_result;
                lat_wdata <= Write_data;
                lat_wreg  <= WriteRegister;
                lat_mtr   <= MemtoReg;
                lat_rw    <= RegWrite;
                lat_store <= MemWrite;
            end
            if (commit) begin
                read_buf <= lat_store ? '0 : ram_rdata;
            end
        end
    end

endmodule
